// File: rtl/eva_ahb_regbank.sv
// AHB-lite slave behind the EVA DPI master: register bank, 32-bit down-counting
// timer and a registered, masked 8-bit interrupt vector, with wait/error responses.
module eva_ahb_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_F000,
  parameter logic [31:0] ID_VALUE  = 32'hE7A0_0001
) (
  input  logic        hclk,
  input  logic        hrest,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [2:0]  hsize,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [7:0]  interrupt
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] R_ID      = 3'd0;
  localparam logic [2:0] R_SCRATCH = 3'd1;
  localparam logic [2:0] R_CTRL    = 3'd2;
  localparam logic [2:0] R_LOAD    = 3'd3;
  localparam logic [2:0] R_VALUE   = 3'd4;
  localparam logic [2:0] R_STATUS  = 3'd5;
  localparam logic [2:0] R_SET     = 3'd6;
  localparam logic [2:0] R_WAIT    = 3'd7;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        xfer_q, xfer_d;
  logic        wr_q, wr_d;
  logic [2:0]  reg_q, reg_d;
  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [7:0]  interrupt_q, interrupt_d;

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  status_q, status_d;
  logic [3:0]  wait_q, wait_d;

  logic        accept;
  logic        legal;
  logic        we;
  logic [7:0]  hw_set, sw_set, w1c;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        unused_htrans0;

  assign unused_htrans0 = htrans[0];

  assign accept = hready && htrans[1] && ((haddr & BASE_MASK) == BASE_ADDR);
  assign legal  = (haddr[11:5] == 7'd0) && (hsize == 3'b010);
  // xfer_q marks the final cycle of a legal data phase; writes commit at its end
  assign we     = xfer_q && wr_q;

  always_comb begin
    scratch_d = scratch_q;
    load_d    = load_q;
    value_d   = value_q;
    en_d      = en_q;
    ar_d      = ar_q;
    mask_d    = mask_q;
    wait_d    = wait_q;
    hw_set    = 8'd0;
    sw_set    = 8'd0;
    w1c       = 8'd0;
    if (en_q) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        hw_set[0] = 1'b1;
        if (ar_q) value_d = load_q;
        else      en_d    = 1'b0;
      end
    end
    // bus writes come last so a LOAD or CTRL write overrides the timer's own update
    if (we) begin
      case (reg_q)
        R_SCRATCH: scratch_d = hwdata;
        R_CTRL: begin
          en_d   = hwdata[0];
          ar_d   = hwdata[1];
          mask_d = hwdata[15:8];
        end
        R_LOAD: begin
          load_d  = hwdata;
          value_d = hwdata;
        end
        R_STATUS: w1c    = hwdata[7:0];
        R_SET:    sw_set = hwdata[7:0];
        R_WAIT:   wait_d = hwdata[3:0];
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_status
      assign status_d[gi]    = (status_q[gi] & ~w1c[gi]) | hw_set[gi] | sw_set[gi];
      assign interrupt_d[gi] = status_q[gi] & mask_q[gi];
    end
  endgenerate

  // Reads return the value the register holds during the completing cycle,
  // so a read pipelined right behind a write sees the new data.
  assign rd_sel = (state_q == S_WAIT) ? reg_q : haddr[4:2];

  always_comb begin
    case (rd_sel)
      R_ID:      rd_data = ID_VALUE;
      R_SCRATCH: rd_data = scratch_d;
      R_CTRL:    rd_data = {16'd0, mask_d, 6'd0, ar_d, en_d};
      R_LOAD:    rd_data = load_d;
      R_VALUE:   rd_data = value_d;
      R_STATUS:  rd_data = {24'd0, status_d};
      R_WAIT:    rd_data = {28'd0, wait_d};
      default:   rd_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    reg_d       = reg_q;
    xfer_d      = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    hrdata_d    = 32'd0;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = S_IDLE;
          xfer_d   = 1'b1;
          hrdata_d = wr_q ? 32'd0 : rd_data;
        end else begin
          hreadyout_d = 1'b0;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
        hresp_d = RESP_ERROR;
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          wr_d  = hwrite;
          reg_d = haddr[4:2];
          if (!legal) begin
            state_d     = S_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERROR;
          end else if (wait_q == 4'd0) begin
            xfer_d   = 1'b1;
            hrdata_d = hwrite ? 32'd0 : rd_data;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = wait_q;
            hreadyout_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      xfer_q      <= 1'b0;
      wr_q        <= 1'b0;
      reg_q       <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      hrdata_q    <= 32'd0;
      interrupt_q <= 8'd0;
      scratch_q   <= 32'd0;
      load_q      <= 32'd0;
      value_q     <= 32'd0;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      mask_q      <= 8'd0;
      status_q    <= 8'd0;
      wait_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xfer_q      <= xfer_d;
      wr_q        <= wr_d;
      reg_q       <= reg_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      interrupt_q <= interrupt_d;
      scratch_q   <= scratch_d;
      load_q      <= load_d;
      value_q     <= value_d;
      en_q        <= en_d;
      ar_q        <= ar_d;
      mask_q      <= mask_d;
      status_q    <= status_d;
      wait_q      <= wait_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign interrupt = interrupt_q;
endmodule

// File: tb/tb_eva_ahb_regbank.sv
// Scoreboard bench for eva_ahb_regbank: a pipelined AHB driver queues expected
// responses, a negedge monitor pops and compares them as data phases complete.
module tb_eva_ahb_regbank;
  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam logic [31:0] A_ID      = 32'h4000_0000;
  localparam logic [31:0] A_SCRATCH = 32'h4000_0004;
  localparam logic [31:0] A_CTRL    = 32'h4000_0008;
  localparam logic [31:0] A_LOAD    = 32'h4000_000C;
  localparam logic [31:0] A_VALUE   = 32'h4000_0010;
  localparam logic [31:0] A_STATUS  = 32'h4000_0014;
  localparam logic [31:0] A_SET     = 32'h4000_0018;
  localparam logic [31:0] A_WAIT    = 32'h4000_001C;

  logic        hclk = 1'b0;
  logic        hrest = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [31:0] hwdata = 32'd0;
  logic [2:0]  hsize = 3'b010;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [7:0]  interrupt;

  assign hready = hreadyout;

  eva_ahb_regbank dut (
    .hclk(hclk), .hrest(hrest), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .hsize(hsize), .hready(hready), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .interrupt(interrupt)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [7:0]  waits;
  } exp_t;

  typedef struct packed {
    logic        idle;
    logic        wr;
    logic        dp;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic [1:0]  eresp;
    logic [7:0]  ewaits;
  } op_t;

  op_t  op_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic idle, input logic wr, input logic dp, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] edata,
                     input logic [1:0] eresp, input int ewaits);
    op_t o;
    o.idle = idle; o.wr = wr; o.dp = dp; o.size = size; o.addr = addr;
    o.wdata = wdata; o.edata = edata; o.eresp = eresp; o.ewaits = ewaits[7:0];
    op_q.push_back(o);
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input int w);
    add(1'b0, 1'b1, 1'b1, 3'b010, a, d, 32'd0, 2'b00, w);
  endtask
  task automatic rd_op(input logic [31:0] a, input logic [31:0] e, input int w);
    add(1'b0, 1'b0, 1'b1, 3'b010, a, 32'd0, e, 2'b00, w);
  endtask
  task automatic err_op(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    add(1'b0, wr, 1'b1, sz, a, 32'h1234_5678, 32'd0, 2'b01, 1);
  endtask
  task automatic oor_op(input logic [31:0] a, input logic [31:0] d);
    add(1'b0, 1'b1, 1'b0, 3'b010, a, d, 32'd0, 2'b00, 0);
  endtask
  task automatic idle_op();
    add(1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 2'b00, 0);
  endtask

  // Pipelined master: address of op k overlaps the data phase of op k-1.
  task automatic run_ops();
    op_t cur, dp;
    bit  have_cur, have_dp;
    int  guard;
    have_dp = 1'b0;
    cur = '0;
    while (op_q.size() > 0 || have_dp) begin
      have_cur = 1'b0;
      if (op_q.size() > 0) begin
        cur = op_q.pop_front();
        have_cur = !cur.idle;
      end
      if (have_cur) begin
        htrans = 2'b10; hwrite = cur.wr; haddr = cur.addr; hsize = cur.size;
        if (cur.dp)
          exp_q.push_back('{addr: cur.addr, data: cur.edata, resp: cur.eresp, waits: cur.ewaits});
      end else begin
        htrans = 2'b00;
      end
      if (have_dp) hwdata = dp.wdata;
      guard = 0;
      do begin
        @(negedge hclk);
        guard++;
      end while (!hready && guard < 50);
      if (!hready) begin
        n_checks++; n_fail++;
        $display("FAIL hready_timeout: hready stuck at %0b, required 1", hready);
        htrans = 2'b00;
        op_q.delete();
        return;
      end
      @(posedge hclk); #1;
      dp = cur;
      have_dp = have_cur;
    end
    htrans = 2'b00;
  endtask

  task automatic sync();
    @(posedge hclk); #1;
  endtask

  exp_t cur_exp;
  bit   in_dp = 1'b0;
  int   mon_waits = 0;
  bit   mid_bad = 1'b0;

  always @(negedge hclk) begin
    if (hrest) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        if (!hreadyout) begin
          mon_waits++;
          if (hresp !== cur_exp.resp || hrdata !== 32'd0) mid_bad = 1'b1;
        end else begin
          $display("txn addr=%h hresp=%0d hrdata=%h waits=%0d", cur_exp.addr, hresp, hrdata, mon_waits);
          chk($sformatf("hrdata@%h", cur_exp.addr), hrdata, cur_exp.data);
          chk($sformatf("hresp@%h", cur_exp.addr), {30'd0, hresp}, {30'd0, cur_exp.resp});
          chk($sformatf("waits@%h", cur_exp.addr), mon_waits, {24'd0, cur_exp.waits});
          chk($sformatf("wait_cycle_bus@%h", cur_exp.addr), {31'd0, mid_bad}, 32'd0);
          in_dp = 1'b0;
        end
      end
      if (hready && htrans[1] && ((haddr & 32'hFFFF_F000) == BASE)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_transfer: got data phase at %h, required none", haddr);
        end else begin
          cur_exp = exp_q.pop_front();
          in_dp = 1'b1;
          mon_waits = 0;
          mid_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // reset state
    @(negedge hclk);
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp", {30'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_interrupt", {24'd0, interrupt}, 32'd0);
    #2 hrest = 1'b0;
    sync();

    // basic read/write, back-to-back read after write
    wr_op(A_SCRATCH, 32'hA5A5_5A5A, 0);
    rd_op(A_SCRATCH, 32'hA5A5_5A5A, 0);
    rd_op(A_ID, 32'hE7A0_0001, 0);
    run_ops();

    // wait states: WAIT sampled at address acceptance
    wr_op(A_WAIT, 32'd3, 0);
    idle_op();
    rd_op(A_SCRATCH, 32'hA5A5_5A5A, 3);
    rd_op(A_WAIT, 32'd3, 3);
    wr_op(A_WAIT, 32'd0, 3);
    idle_op();
    rd_op(A_SCRATCH, 32'hA5A5_5A5A, 0);
    run_ops();

    // errors, out-of-region, read-only writes
    err_op(1'b0, 32'h4000_0040, 3'b010);
    rd_op(A_ID, 32'hE7A0_0001, 0);
    err_op(1'b1, A_SCRATCH, 3'b000);
    idle_op();
    rd_op(A_SCRATCH, 32'hA5A5_5A5A, 0);
    oor_op(32'h4000_1004, 32'hDEAD_BEEF);
    rd_op(A_SCRATCH, 32'hA5A5_5A5A, 0);
    wr_op(A_ID, 32'd0, 0);
    wr_op(A_VALUE, 32'h55, 0);
    rd_op(A_ID, 32'hE7A0_0001, 0);
    rd_op(A_VALUE, 32'd0, 0);
    run_ops();

    // one-shot timer: LOAD=5, enable with mask bit 0
    wr_op(A_LOAD, 32'd5, 0);
    wr_op(A_CTRL, 32'h0000_0101, 0);
    run_ops();
    cnt = 0;
    do begin
      @(negedge hclk);
      cnt++;
    end while (!interrupt[0] && cnt < 40);
    chk("irq0_latency", cnt, 32'd8);
    sync();
    rd_op(A_CTRL, 32'h0000_0100, 0);
    rd_op(A_STATUS, 32'h0000_0001, 0);
    rd_op(A_VALUE, 32'd0, 0);
    rd_op(A_LOAD, 32'd5, 0);
    run_ops();
    wr_op(A_STATUS, 32'h1, 0);
    run_ops();
    @(negedge hclk);
    chk("irq0_before_clear", {31'd0, interrupt[0]}, 32'd1);
    @(negedge hclk);
    chk("irq_after_clear", {24'd0, interrupt}, 32'd0);
    sync();

    // auto-reload, period 3; W1C colliding with expiry keeps the bit
    wr_op(A_LOAD, 32'd2, 0);
    wr_op(A_CTRL, 32'h0000_FF03, 0);
    run_ops();
    idle_op();
    wr_op(A_STATUS, 32'h1, 0);
    rd_op(A_STATUS, 32'h1, 0);
    run_ops();
    idle_op();
    wr_op(A_STATUS, 32'h1, 0);
    rd_op(A_STATUS, 32'h0, 0);
    run_ops();
    rd_op(A_STATUS, 32'h1, 0);
    rd_op(A_CTRL, 32'h0000_FF03, 0);
    run_ops();

    // software SET
    wr_op(A_SET, 32'h80, 0);
    run_ops();
    @(negedge hclk);
    chk("irq7_before", {31'd0, interrupt[7]}, 32'd0);
    @(negedge hclk);
    chk("irq7_after", {31'd0, interrupt[7]}, 32'd1);
    sync();
    rd_op(A_SET, 32'd0, 0);
    run_ops();

    // asynchronous reset in the middle of a waited read
    wr_op(A_WAIT, 32'd5, 0);
    run_ops();
    exp_q.push_back('{addr: A_SCRATCH, data: 32'd0, resp: 2'b00, waits: 8'd5});
    htrans = 2'b10; hwrite = 1'b0; haddr = A_SCRATCH; hsize = 3'b010;
    @(negedge hclk);
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    chk("pre_rst_wait_low", {31'd0, hreadyout}, 32'd0);
    chk("pre_rst_irq7", {31'd0, interrupt[7]}, 32'd1);
    #2 hrest = 1'b1;
    #1;
    chk("async_rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("async_rst_hrdata", hrdata, 32'd0);
    chk("async_rst_hresp", {30'd0, hresp}, 32'd0);
    chk("async_rst_interrupt", {24'd0, interrupt}, 32'd0);
    @(negedge hclk);
    #2 hrest = 1'b0;
    sync();
    rd_op(A_SCRATCH, 32'd0, 0);
    rd_op(A_WAIT, 32'd0, 0);
    rd_op(A_CTRL, 32'd0, 0);
    rd_op(A_STATUS, 32'd0, 0);
    run_ops();
    repeat (3) @(negedge hclk);

    chk("scoreboard_drained", exp_q.size() + (in_dp ? 1 : 0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
